weight_bram_reader: RTL and testbench

//  Read-side sequencer for one single-port weight BRAM. It is the read master for that BRAM.

---
 rtl/weight_bram_reader_if.sv | 31 +++
 rtl/weight_bram_reader.sv | 114 +++++++++++
 tb/tb_weight_bram_reader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/weight_bram_reader_if.sv
// Bus bundle for the weight BRAM reader: BRAM port plus the weight stream.
// The reader is the master of both sides; the BRAM and consumer form the slave.
interface weight_bram_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] BRAM_ADDR;
    logic              BRAM_EN;
    logic              BRAM_WE;
    logic [DATA_W-1:0] BRAM_DI;
    logic [DATA_W-1:0] BRAM_DO;
    logic [DATA_W-1:0] W_DATA;
    logic [ADDR_W-1:0] W_IDX;
    logic              W_VALID;
    logic              W_READY;
    logic              W_LAST;

    modport master (
        output BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_DI,
        input  BRAM_DO,
        output W_DATA, W_IDX, W_VALID, W_LAST,
        input  W_READY
    );

    modport slave (
        input  BRAM_ADDR, BRAM_EN, BRAM_WE, BRAM_DI,
        output BRAM_DO,
        input  W_DATA, W_IDX, W_VALID, W_LAST,
        output W_READY
    );
endinterface

// File: rtl/weight_bram_reader.sv
// Read-side sequencer for a single-port weight BRAM. Fetches addresses
// 0..DEPTH-1 on START and streams them out through a 2-entry buffer with
// full valid/ready backpressure. The BRAM is never written.
module weight_bram_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 28
) (
    input  logic CLK,
    input  logic RST,
    input  logic START,
    output logic BUSY,
    output logic DONE,
    weight_bram_reader_if.master bus
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  issue_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] buf_data [2];
    logic [ADDR_W-1:0] buf_idx  [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count;

    logic              valid, pop, room, issue, inflight, last_issue, head_last;
    logic [ADDR_W-1:0] issue_addr;

    // The BRAM samples the address on the negedge of the issue cycle, so the
    // read in flight is the issue cycle itself; its data is pushed at the
    // posedge closing that cycle.
    assign valid      = (count != 2'd0);
    assign pop        = valid & bus.W_READY;
    assign room       = (count < 2'd2) | pop;
    assign issue      = (state == S_FETCH) & room;
    assign inflight   = issue;
    assign issue_addr = issue_cnt[ADDR_W-1:0];
    assign last_issue = (issue_cnt == CNT_W'(DEPTH - 1));
    assign head_last  = valid & (buf_idx[rd_ptr] == ADDR_W'(DEPTH - 1));

    assign bus.BRAM_EN   = issue;
    assign bus.BRAM_ADDR = issue ? issue_addr : addr_q;
    assign bus.BRAM_WE   = 1'b0;
    assign bus.BRAM_DI   = '0;

    assign bus.W_VALID = valid;
    assign bus.W_DATA  = valid ? buf_data[rd_ptr] : '0;
    assign bus.W_IDX   = valid ? buf_idx[rd_ptr]  : '0;
    assign bus.W_LAST  = head_last;

    assign BUSY = (state == S_FETCH) | (state == S_DRAIN);
    assign DONE = (state == S_DONE);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (START) state_nxt = S_FETCH;
            S_FETCH: if (issue && last_issue) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && head_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Issue counter and held BRAM address
    always_ff @(posedge CLK) begin
        if (RST) begin
            issue_cnt <= '0;
            addr_q    <= '0;
        end else begin
            if (state == S_IDLE && START) issue_cnt <= '0;
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
                addr_q    <= issue_addr;
            end
        end
    end

    // Buffer occupancy and pointers; a push and a pop at one edge both apply
    always_ff @(posedge CLK) begin
        if (RST) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (inflight) wr_ptr <= ~wr_ptr;
            if (pop)      rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Buffer storage captures BRAM data and its address
    always_ff @(posedge CLK) begin
        if (!RST && inflight) begin
            buf_data[wr_ptr] <= bus.BRAM_DO;
            buf_idx[wr_ptr]  <= issue_addr;
        end
    end
endmodule

// File: tb/tb_weight_bram_reader.sv
// Self-checking bench for weight_bram_reader: randomized backpressure and
// data against a transaction-level model (words issued / words taken).
module tb_weight_bram_reader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 28;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic START = 1'b0;
    logic BUSY, DONE;
    logic load = 1'b0;

    weight_bram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    weight_bram_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [DATA_W-1:0] mem     [2**ADDR_W];
    logic [DATA_W-1:0] mem_ref [2**ADDR_W];

    // BRAM model: samples on negedge, read data ready by the next posedge
    always @(negedge CLK) begin
        if (load) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] = mem_ref[i];
        end else if (bus.BRAM_EN) begin
            if (bus.BRAM_WE) mem[bus.BRAM_ADDR] = bus.BRAM_DI;
            bus.BRAM_DO = mem[bus.BRAM_ADDR];
        end
    end

    int checks = 0;
    int failures = 0;

    // model: phase 0 idle, 1 busy, 2 done-pulse
    int phase = 0;
    int issued = 0;
    int taken = 0;
    int last_addr = 0;
    int starts = 0;
    int words = 0;
    int en_seen = 0;
    int cyc = 0;
    int start_at = 0;
    int done_at = 0;
    logic known = 1'b0;
    logic prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic st, input logic rdy, input logic rs);
        int occ;
        logic pop_exp, en_exp;
        @(posedge CLK);
        #1;
        START = st;
        bus.W_READY = rdy;
        RST = rs;
        @(negedge CLK);
        cyc++;
        if (bus.BRAM_EN) en_seen++;
        if (DONE) done_at = cyc;
        occ = issued - taken;
        pop_exp = (occ > 0) && rdy;
        en_exp = (phase == 1) && (issued < DEPTH) && ((occ - int'(pop_exp)) < 2);
        if (known) begin
            check("busy", BUSY, phase == 1);
            check("done", DONE, phase == 2);
            check("valid", bus.W_VALID, occ > 0);
            check("bram_en", bus.BRAM_EN, en_exp);
            check("bram_we", bus.BRAM_WE, 1'b0);
            check("bram_di", bus.BRAM_DI, '0);
            if (en_exp) check("bram_addr", bus.BRAM_ADDR, issued);
            else        check("addr_hold", bus.BRAM_ADDR, last_addr);
            check("last", bus.W_LAST, (occ > 0) && (taken == DEPTH - 1));
            if (occ > 0) begin
                check("w_idx", bus.W_IDX, taken);
                check("w_data", bus.W_DATA, mem_ref[taken]);
            end
            if (prev_stall) check("stall_stable", bus.W_DATA, prev_data);
        end
        prev_stall = (occ > 0) && !rdy;
        prev_data = bus.W_DATA;
        if (rs) begin
            phase = 0; issued = 0; taken = 0; last_addr = 0;
            prev_stall = 1'b0;
            known = 1'b1;
        end else begin
            if (pop_exp) words++;
            case (phase)
                0: if (st) begin
                    phase = 1; issued = 0; taken = 0; starts++;
                    start_at = cyc;
                end
                1: begin
                    if (en_exp) begin last_addr = issued; issued++; end
                    if (pop_exp) begin
                        if (taken == DEPTH - 1) phase = 2;
                        taken++;
                    end
                end
                default: phase = 0;
            endcase
        end
    endtask

    // mode 1: ready held high, otherwise random 50%
    task automatic run(input int mode, input int budget);
        int n = 0;
        while (phase != 0 && n < budget) begin
            step(1'b0, (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        check("run_timeout", phase, 0);
    endtask

    task automatic load_mem(input logic rnd);
        for (int i = 0; i < 2**ADDR_W; i++)
            mem_ref[i] = rnd ? DATA_W'($urandom) : DATA_W'(16'h0100 + i);
        load = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        load = 1'b0;
    endtask

    initial begin
        int s0, n;
        bus.W_READY = 1'b0;
        bus.BRAM_DO = '0;
        for (int i = 0; i < 2**ADDR_W; i++) mem_ref[i] = '0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        load_mem(1'b0);

        // nominal
        words = 0;
        step(1'b1, 1'b1, 1'b0);
        run(1, 200);
        check("t1_words", words, DEPTH);
        check("t1_done_latency", done_at - start_at, 30);

        // random backpressure with random data
        for (int r = 0; r < 3; r++) begin
            load_mem(1'b1);
            words = 0;
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            run(2, 1000);
            check("t2_words", words, DEPTH);
        end

        // full stall for 10 cycles from START
        load_mem(1'b0);
        en_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0);
        check("t3_en_pulses", en_seen, 2);
        check("t3_head", bus.W_DATA, 16'h0100);
        words = 0;
        run(1, 200);
        check("t3_words", words, DEPTH);

        // START while busy and during DONE is ignored
        s0 = starts;
        words = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 34; k++) step((k == 5) || (k == 30), 1'b1, 1'b0);
        check("t4_done_seen", done_at - start_at, 30);
        check("t4_starts", starts - s0, 1);
        check("t4_words", words, DEPTH);
        words = 0;
        step(1'b1, 1'b1, 1'b0);
        run(1, 200);
        check("t4_rerun_words", words, DEPTH);

        // reset mid-fetch with a read in flight
        step(1'b1, 1'b1, 1'b0);
        n = 0;
        while (taken < 10 && n < 100) begin step(1'b0, 1'b1, 1'b0); n++; end
        check("t5_reached", taken, 10);
        check("t5_inflight", bus.BRAM_EN, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        check("t5_valid", bus.W_VALID, 1'b0);
        check("t5_busy", BUSY, 1'b0);
        check("t5_en", bus.BRAM_EN, 1'b0);
        words = 0;
        step(1'b1, 1'b1, 1'b0);
        run(2, 1000);
        check("t5_words", words, DEPTH);

        // BRAM contents untouched
        for (int i = 0; i < DEPTH; i++) check("t6_mem", mem[i], mem_ref[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
